// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory load/store initiator: access sizes,
// FSM states and the memory write/read strobe polarity.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic MEM_WR = 1'b0;
  localparam logic MEM_RD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_MERGE,
    ST_WR,
    ST_FIN
  } state_e;

  // The reserved size code 11 behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Big-endian lane steering for the 32-bit data memory: sub-word load extraction
// with sign/zero extension, and sub-word insertion for read-modify-write stores.
module lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic [31:0] word_in,
  input  logic [31:0] ins_data,
  output logic [31:0] load_c,
  output logic [31:0] merge_c
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Offset 0 is the most significant lane, so the shift is (3 - off) bytes.
  assign byte_sh = {~off, 3'b000};
  assign half_sh = off[1] ? 5'd0 : 5'd16;
  assign byte_v  = 8'(word_in >> byte_sh);
  assign half_v  = 16'(word_in >> half_sh);

  always_comb begin
    load_c  = word_in;
    merge_c = ins_data;
    case (size)
      SZ_BYTE: begin
        load_c  = uns ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
        merge_c = (word_in & ~(32'h0000_00FF << byte_sh)) |
                  ({24'h0, ins_data[7:0]} << byte_sh);
      end
      SZ_HALF: begin
        load_c  = uns ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
        merge_c = (word_in & ~(32'h0000_FFFF << half_sh)) |
                  ({16'h0, ins_data[15:0]} << half_sh);
      end
      default: begin
        load_c  = word_in;
        merge_c = ins_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator driving a word-organised data memory.
// Define MEM_ACCESS_ALIGN_CHECK_EN to fault misaligned half/word requests with err.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned data_WIDTH = 32,
  parameter int unsigned addr_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  output logic                  ready,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  uns,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  done,
  output logic                  err,
  output logic                  mem_cs,
  output logic                  mem_wr_rd,
  output logic [addr_WIDTH-1:0] mem_addr,
  output logic [data_WIDTH-1:0] mem_din,
  input  logic [data_WIDTH-1:0] mem_dout
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [1:0]            off_q, off_d;
  logic [addr_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  rd_wait_q, rd_wait_d;

  logic [1:0]  size_n;
  logic        misalign;
  logic [1:0]  off_fix;
  logic [31:0] load_c;
  logic [31:0] merge_c;
  logic        unused_addr_c;

  assign unused_addr_c = ^addr[31:addr_WIDTH+2];

  lane_align u_lane_align (
    .size     (size_q),
    .uns      (uns_q),
    .off      (off_q),
    .word_in  (32'(mem_dout)),
    .ins_data (wdata_q),
    .load_c   (load_c),
    .merge_c  (merge_c)
  );

  always_comb begin
    size_n = norm_size(size);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    misalign = ((size_n == SZ_HALF) && addr[0]) ||
               ((size_n == SZ_WORD) && (addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    // Without the alignment check, offending low offset bits are dropped.
    case (size_n)
      SZ_BYTE: off_fix = addr[1:0];
      SZ_HALF: off_fix = {addr[1], 1'b0};
      default: off_fix = 2'b00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    off_d     = off_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    rd_wait_d = rd_wait_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d      = we;
          size_d    = size_n;
          uns_d     = uns;
          off_d     = off_fix;
          waddr_d   = addr[addr_WIDTH+1:2];
          wdata_d   = wdata;
          err_d     = misalign;
          rd_wait_d = 1'b0;
          if (misalign)                    state_d = ST_FIN;
          else if (we && size_n == SZ_WORD) state_d = ST_WR;
          else                             state_d = ST_RD;
        end
      end
      // Loads hold RD one extra cycle so the registered memory output settles.
      ST_RD: begin
        if (we_q) begin
          state_d = ST_MERGE;
        end else if (!rd_wait_q) begin
          rd_wait_d = 1'b1;
        end else begin
          rdata_d = load_c;
          state_d = ST_FIN;
        end
      end
      ST_MERGE: state_d = ST_FIN;
      ST_WR:    state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
      off_q     <= 2'b00;
      waddr_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      rd_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      off_q     <= off_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      rd_wait_q <= rd_wait_d;
    end
  end

  // Memory port decodes only from the state register; MERGE data is combinational.
  assign ready     = (state_q == ST_IDLE) && !rst;
  assign done      = (state_q == ST_FIN);
  assign err       = done && err_q;
  assign rdata     = rdata_q;
  assign mem_cs    = (state_q == ST_RD) || (state_q == ST_MERGE) || (state_q == ST_WR);
  assign mem_wr_rd = ((state_q == ST_MERGE) || (state_q == ST_WR)) ? MEM_WR : MEM_RD;
  assign mem_addr  = waddr_q;
  assign mem_din   = (state_q == ST_MERGE) ? data_WIDTH'(merge_c) :
                     (state_q == ST_WR)    ? data_WIDTH'(wdata_q) : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver pushes expected completions,
// a negedge monitor pops and compares them against done/rdata/err/latency.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, done, err, mem_cs, mem_wr_rd;
  logic [31:0] rdata, mem_din, mem_dout;
  logic [9:0]  mem_addr;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .we(we), .size(size),
    .uns(uns), .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
    .mem_cs(mem_cs), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Registered-read data memory; garbage on dout when the last edge was not a read.
  logic [31:0] mem [1024];
  logic [31:0] dout_q = '0;
  logic        rd_prev = 1'b0;
  int          wr_count = 0;
  int          cyc = 0;

  initial for (int i = 0; i < 1024; i++) mem[i] = '0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_prev <= mem_cs && mem_wr_rd;
    if (mem_cs && mem_wr_rd) dout_q <= mem[mem_addr];
    if (mem_cs && !mem_wr_rd) begin
      mem[mem_addr] <= mem_din;
      wr_count      <= wr_count + 1;
    end
  end
  assign mem_dout = rd_prev ? dout_q : 32'hDEAD_0BAD;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          acc;
    int          lat;
    string       nm;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] run_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req_v);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no completion at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk({e.nm, "_rdata"}, rdata, e.rd);
        chk({e.nm, "_err"}, 32'(err), 32'(e.er));
        chk({e.nm, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end else if (q.size() > 0 && cyc > q[0].acc + 8) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done expected done %0d cycles after accept", e.nm, e.lat);
    end
  end

  task automatic push_exp(input logic w, input logic [31:0] ld, input logic er,
                          input int lat, input string nm);
    exp_t x;
    if (!w && !er) run_rdata = ld;
    x.rd  = run_rdata;
    x.er  = er;
    x.acc = cyc + 1;
    x.lat = lat;
    x.nm  = nm;
    q.push_back(x);
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ld,
                       input logic er, input int lat, input logic [9:0] wa, input string nm);
    @(negedge clk);
    we = w; size = sz; uns = u; addr = a; wdata = wd; req = 1'b1;
    for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL %s_ready_timeout: got ready=0 expected ready=1", nm);
      req = 1'b0;
      return;
    end
    push_exp(w, ld, er, lat, nm);
    @(posedge clk);
    @(negedge clk);
    if (er) chk({nm, "_no_cs"}, 32'(mem_cs), 32'd0);
    else    chk({nm, "_mem_addr"}, {21'd0, mem_cs, mem_addr}, {21'd0, 1'b1, wa});
    req = 1'b0;
  endtask

  int n_acc;
  int wr_snap;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_mem_ctl", {30'd0, mem_cs, mem_wr_rd}, 32'd1);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, '0, 0, 1, 10'd4, "ws_10");
    issue(0, 2'b10, 0, 32'h10, '0, 32'hDEADBEEF, 0, 2, 10'd4, "wl_10");
    issue(1, 2'b10, 0, 32'h20, 32'h11223344, '0, 0, 1, 10'd8, "ws_20");
    issue(1, 2'b00, 0, 32'h22, 32'h123456AA, '0, 0, 2, 10'd8, "bs_22");
    issue(0, 2'b10, 0, 32'h20, '0, 32'h1122AA44, 0, 2, 10'd8, "wl_20");
    chk("mem_word_20", mem[8], 32'h1122AA44);
    issue(1, 2'b10, 0, 32'h30, 32'h80FF7F01, '0, 0, 1, 10'd12, "ws_30");
    issue(0, 2'b00, 0, 32'h30, '0, 32'hFFFFFF80, 0, 2, 10'd12, "bl_s_30");
    issue(0, 2'b00, 1, 32'h31, '0, 32'h000000FF, 0, 2, 10'd12, "bl_u_31");
    issue(0, 2'b01, 0, 32'h32, '0, 32'h00007F01, 0, 2, 10'd12, "hl_s_32");
    issue(0, 2'b01, 0, 32'h30, '0, 32'hFFFF80FF, 0, 2, 10'd12, "hl_s_30");
    issue(0, 2'b01, 1, 32'h30, '0, 32'h000080FF, 0, 2, 10'd12, "hl_u_30");
    issue(1, 2'b01, 0, 32'h30, 32'hFFFFBEEF, '0, 0, 2, 10'd12, "hs_30");
    issue(0, 2'b11, 1, 32'h30, '0, 32'hBEEF7F01, 0, 2, 10'd12, "wl11_30");
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    issue(0, 2'b01, 0, 32'h33, '0, '0, 1, 0, 10'd12, "hl_mis_33");
`else
    issue(0, 2'b01, 0, 32'h33, '0, 32'h00007F01, 0, 2, 10'd12, "hl_mis_33");
`endif
    issue(0, 2'b00, 0, 32'h33, '0, 32'h00000001, 0, 2, 10'd12, "bl_s_33");

    // Reset in the MERGE cycle of a byte store must abort the write.
    repeat (4) @(negedge clk);
    wr_snap = wr_count;
    we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h21; wdata = 32'h55; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("merge_cycle_ctl", {30'd0, mem_cs, mem_wr_rd}, 32'd2);
    rst = 1'b1;
    #1;
    chk("rst_drops_cs", 32'(mem_cs), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_rdata = '0;
    chk("rst_no_write", 32'(wr_count - wr_snap), 32'd0);
    chk("rst_mem_unchanged", mem[8], 32'h1122AA44);
    @(negedge clk);
    chk("ready_after_rst", {30'd0, ready, done}, 32'd2);
    issue(0, 2'b10, 0, 32'h20, '0, 32'h1122AA44, 0, 2, 10'd8, "wl_after_rst");

    // req held high: one acceptance per IDLE window.
    @(negedge clk);
    wr_snap = wr_count;
    we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h10; req = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (ready) begin
        push_exp(0, 32'hDEADBEEF, 0, 2, "held_load");
        n_acc++;
      end
      @(negedge clk);
    end
    req = 1'b0;
    chk("held_acceptances", 32'(n_acc), 32'd3);
    chk("held_no_write", 32'(wr_count - wr_snap), 32'd0);

    // Back-to-back load then store, then a load to confirm exactly one write.
    wr_snap = wr_count;
    issue(0, 2'b10, 0, 32'h20, '0, 32'h1122AA44, 0, 2, 10'd8, "b2b_load");
    issue(1, 2'b00, 0, 32'h23, 32'h00000077, '0, 0, 2, 10'd8, "b2b_store");
    issue(0, 2'b10, 0, 32'h20, '0, 32'h1122AA77, 0, 2, 10'd8, "b2b_check");
    chk("b2b_one_write", 32'(wr_count - wr_snap), 32'd1);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
